fifo_param: RTL and testbench
=============================

Name: fifo_param

Overview:
Parametrised synchronous FIFO and next-generation successor to the fixed-size fifo block. Width, depth and almost-flag thresholds are configurable, and depth need not be a power of two. Adds an occupancy count, separate single-cycle overflow/underflow pulses and a sticky error with explicit clear. Sits between a producer and a consumer in one clock domain and is driven through fifo_if-style push/pop tasks.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 16, number of entries (2..1024; any integer, not only power of two)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
CW, $clog2(DEPTH+1), derived, width of count; not to be overridden

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
push  in  1  write request; data_in is captured when the push is accepted
pop  in  1  read request
data_in  in  WIDTH  write data
err_clr  in  1  clears sticky error
data_out  out  WIDTH  registered read data, holds last popped word
empty  out  1  count == 0
almost_empty  out  1  count <= AE_LEVEL
almost_full  out  1  count >= AF_LEVEL
full  out  1  count == DEPTH
count  out  CW  current occupancy
overflow  out  1  one-cycle pulse, push rejected because FIFO is full
underflow  out  1  one-cycle pulse, pop rejected because FIFO is empty
error  out  1  sticky; set by overflow or underflow

Behaviour:
- Reset asynchronously clears wr_ptr, rd_ptr, count, data_out, overflow, underflow and error to 0. After reset: empty=1, almost_empty=1, almost_full=0, full=0. Memory contents are not reset.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge. All in-flight data is discarded.
- All flags decode combinationally from the registered count, so they change only after a clock edge or reset.
- Accepted push: mem[wr_ptr] <= data_in; wr_ptr advances.
- Accepted pop: data_out <= mem[rd_ptr] on the same edge; rd_ptr advances. Data is visible one cycle after pop is sampled.
- Pointers wrap from DEPTH-1 to 0 by explicit compare, not modulo-2^n.
- Push only:
  - not full: accepted, count+1.
  - full: rejected, overflow=1 for one cycle, no state change.
- Pop only:
  - not empty: accepted, count-1.
  - empty: rejected, underflow=1 for one cycle, data_out holds its value.
- Push and pop together:
  - 0<count<DEPTH: both accepted, count unchanged.
  - count==DEPTH: both accepted (the pop frees a slot), count stays DEPTH, no overflow.
  - count==0: push accepted, pop rejected with underflow=1, count becomes 1, data_out unchanged. There is no fall-through.
- Rejected operations never move pointers, never change count and never write memory.
- error sets on any cycle with overflow or underflow and holds until err_clr. If set and err_clr occur in the same cycle, set wins.
- overflow and underflow are registered. Each is 0 on any cycle without a new rejection.

Test Plan:
(All scenarios use WIDTH=8, DEPTH=5, AE_LEVEL=1, AF_LEVEL=4.)
1. Reset, then push 0x11..0x15 on consecutive cycles:
   - count goes 1,2,3,4,5; almost_empty drops at count 2; almost_full rises at count 4; full rises at count 5.
   - A 6th push of 0x16 gives overflow=1 for one cycle, error=1, count=5.
2. From scenario 1, pop 5 times:
   - data_out is 0x11..0x15, each one cycle after its pop; empty=1 at the end.
   - A 6th pop gives underflow=1, data_out stays 0x15.
3. Wrap test: push 3, pop 3, push 0x21..0x25, pop 5.
   - data_out is 0x21..0x25 in order, so ordering holds across the pointer wrap at 5.
4. Simultaneous operations:
   - At count 5, push 0xAA with pop: data_out is the oldest entry, count=5, overflow=0.
   - At count 0, push 0xBB with pop: underflow=1, count=1. A following pop returns 0xBB.
5. Error clear:
   - Overflow and err_clr in the same cycle: error stays 1.
   - err_clr alone on the next cycle: error=0.
6. Reset mid-stream:
   - With count=3, assert reset between clock edges: count=0, empty=1, full=0, data_out=0 before the next edge.
   - After reset, a pop gives underflow.

Source files
------------

// File: rtl/fifo_param_if.sv
// rtl/fifo_param_if.sv - push/pop/status bundle between a producer and fifo_param
interface fifo_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic             err_clr;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             almost_empty;
  logic             almost_full;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             error;

  modport master (
    output push, pop, data_in, err_clr,
    input  data_out, empty, almost_empty, almost_full, full, count,
           overflow, underflow, error
  );

  modport slave (
    input  push, pop, data_in, err_clr,
    output data_out, empty, almost_empty, almost_full, full, count,
           overflow, underflow, error
  );
endinterface

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO, any depth, with occupancy and error flags
module fifo_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AE_LEVEL = 2,
  parameter int AF_LEVEL = 14,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input logic        clk,
  input logic        reset,
  fifo_param_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dout_q;
  logic             ovf_q, unf_q, err_q;
  logic             is_empty, is_full, do_push, do_pop, reject;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);
  assign do_pop   = bus.pop && !is_empty;
  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_push  = bus.push && (!is_full || do_pop);
  assign reject   = (bus.push && !do_push) || (bus.pop && !do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ovf_q <= bus.push && !do_push;
      unf_q <= bus.pop && !do_pop;
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (do_pop) begin
        dout_q <= mem[rd_ptr];
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
      // A new rejection outranks a clear in the same cycle.
      if (reject)           err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.count        = count_q;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
  assign bus.error        = err_q;
endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - randomized and directed bench for fifo_param against a queue model
module tb_fifo_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int AE    = 1;
  localparam int AF    = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errs = 0;

  logic [7:0] mq[$];
  logic [7:0] m_dout = '0;
  bit         m_ovf = 0, m_unf = 0, m_err = 0;

  fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AE_LEVEL(AE), .AF_LEVEL(AF)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n = mq.size();
    check({tag, ".count"}, 32'(bus.count), n);
    check({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
    check({tag, ".aempty"}, 32'(bus.almost_empty), 32'(n <= AE));
    check({tag, ".afull"}, 32'(bus.almost_full), 32'(n >= AF));
    check({tag, ".full"}, 32'(bus.full), 32'(n == DEPTH));
    check({tag, ".dout"}, 32'(bus.data_out), 32'(m_dout));
    check({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
    check({tag, ".unf"}, 32'(bus.underflow), 32'(m_unf));
    check({tag, ".err"}, 32'(bus.error), 32'(m_err));
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_ovf = 0;
    m_unf = 0;
    m_err = 0;
  endtask

  task automatic model_step(input bit p, input bit q, input logic [7:0] d, input bit c);
    m_ovf = 0;
    m_unf = 0;
    if (q) begin
      if (mq.size() == 0) m_unf = 1;
      else m_dout = mq.pop_front();
    end
    if (p) begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else mq.push_back(d);
    end
    if (m_ovf || m_unf) m_err = 1;
    else if (c) m_err = 0;
  endtask

  task automatic step(input string tag, input bit p, input bit q, input logic [7:0] d, input bit c);
    @(negedge clk);
    bus.push = p;
    bus.pop = q;
    bus.data_in = d;
    bus.err_clr = c;
    @(posedge clk);
    model_step(p, q, d, c);
    #1;
    check_all(tag);
  endtask

  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    bus.push = 0;
    bus.pop = 0;
    bus.err_clr = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.push = 0;
    bus.pop = 0;
    bus.data_in = '0;
    bus.err_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 5; i++) step("fill", 1, 0, 8'h11 + 8'(i), 0);
    step("ovf", 1, 0, 8'h16, 0);
    step("ovf_clear", 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step("drain", 0, 1, 8'h00, 0);
    step("unf", 0, 1, 8'h00, 0);
    step("clr", 0, 0, 8'h00, 1);

    for (int i = 0; i < 3; i++) step("wpre_push", 1, 0, 8'h01, 0);
    for (int i = 0; i < 3; i++) step("wpre_pop", 0, 1, 8'h00, 0);
    for (int i = 0; i < 5; i++) step("wrap_push", 1, 0, 8'h21 + 8'(i), 0);
    step("full_both", 1, 1, 8'hAA, 0);
    for (int i = 0; i < 5; i++) step("wrap_pop", 0, 1, 8'h00, 0);
    step("empty_both", 1, 1, 8'hBB, 0);
    step("pop_bb", 0, 1, 8'h00, 0);

    for (int i = 0; i < 5; i++) step("refill", 1, 0, 8'h40 + 8'(i), 0);
    step("ovf_and_clr", 1, 0, 8'h50, 1);
    step("clr_alone", 0, 0, 8'h00, 1);
    for (int i = 0; i < 2; i++) step("to3", 0, 1, 8'h00, 0);
    mid_reset("mid_reset");
    step("post_reset_unf", 0, 1, 8'h00, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) mid_reset("rnd_reset");
      else step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
